// File: rtl/renas_mem_responder.sv
// renas_mem_responder: main-memory end of the L2 refill/writeback link.
// Accepts critical-word-first bursts from the L2 controller. Reads return
// BURST_LEN beats starting RD_LATENCY cycles after the request is accepted.
// Writebacks take BURST_LEN data beats and are acknowledged with one beat.
//
// Ports:
//   clk, rst_n                          clock, synchronous active-low reset
//   req_valid/req_ready/req_write/req_addr   burst request (byte address)
//   wdata_valid/wdata/wdata_ready       writeback data beats
//   rsp_valid/rsp_data/rsp_last/rsp_ready    response beats (data 0 on ack)
//   busy                                transaction in progress
//   rsp_err (RENAS_MEM_ECC_ERR_EN only) out-of-range request flag
//
// Optional feature macro: RENAS_MEM_ECC_ERR_EN. When defined, requests with
// address bits above the storage range are flagged: reads return DEADBEEF
// and writes are dropped, with rsp_err set on every response beat.
module renas_mem_responder #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned BURST_LEN  = 4,
    parameter int unsigned MEM_DEPTH  = 1024,
    parameter int unsigned RD_LATENCY = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              wdata_valid,
    input  logic [DATA_W-1:0] wdata,
    output logic              wdata_ready,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_last,
    input  logic              rsp_ready,
`ifdef RENAS_MEM_ECC_ERR_EN
    output logic              rsp_err,
`endif
    output logic              busy
);

    localparam int unsigned IDX_W  = $clog2(MEM_DEPTH);
    localparam int unsigned BEAT_W = $clog2(BURST_LEN);
    localparam int unsigned LAT_W  = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_WAIT  = 3'd1,
        RD_BURST = 3'd2,
        WR_DATA  = 3'd3,
        WR_ACK   = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [LAT_W-1:0]  cnt_q, cnt_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [IDX_W-1:0]  idx_q, idx_d;

    logic              req_ready_q, req_ready_d;
    logic              wdata_ready_q, wdata_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic              rsp_last_q, rsp_last_d;
    logic              busy_q, busy_d;
`ifdef RENAS_MEM_ECC_ERR_EN
    logic              oor_q, oor_d;
    logic              rsp_err_q, rsp_err_d;
`endif

    logic [DATA_W-1:0] mem [MEM_DEPTH];

    logic              req_hs, wr_hs, rsp_hs;
    logic              mem_we;
    logic [IDX_W-1:0]  wr_idx, rd_idx;
    logic              unused_addr;

    // Bits outside the word index only matter for the out-of-range check.
    assign unused_addr = ^req_addr;

    assign req_hs = req_valid && req_ready_q;
    assign wr_hs  = wdata_valid && wdata_ready_q;
    assign rsp_hs = rsp_valid_q && rsp_ready;

    // Critical-word-first: offset within the aligned block wraps at BURST_LEN.
    assign wr_idx = {idx_q[IDX_W-1:BEAT_W], BEAT_W'(idx_q[BEAT_W-1:0] + beat_q)};
    assign rd_idx = {idx_d[IDX_W-1:BEAT_W], BEAT_W'(idx_d[BEAT_W-1:0] + beat_d)};

    // Next-state, counters and storage write enable.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        beat_d  = beat_q;
        idx_d   = idx_q;
        mem_we  = 1'b0;
`ifdef RENAS_MEM_ECC_ERR_EN
        oor_d   = oor_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_hs) begin
                    idx_d  = req_addr[IDX_W+1:2];
                    beat_d = '0;
`ifdef RENAS_MEM_ECC_ERR_EN
                    oor_d  = (req_addr >> (IDX_W + 2)) != '0;
`endif
                    if (req_write) begin
                        state_d = WR_DATA;
                    end else begin
                        cnt_d   = LAT_W'(RD_LATENCY - 1);
                        state_d = RD_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RD_BURST;
                end else begin
                    cnt_d = cnt_q - LAT_W'(1);
                end
            end
            RD_BURST: begin
                if (rsp_hs) begin
                    beat_d = beat_q + BEAT_W'(1);
                    if (beat_q == LAST_BEAT) begin
                        state_d = IDLE;
                    end
                end
            end
            WR_DATA: begin
                if (wr_hs) begin
`ifdef RENAS_MEM_ECC_ERR_EN
                    mem_we = rst_n && !oor_q;
`else
                    mem_we = rst_n;
`endif
                    beat_d = beat_q + BEAT_W'(1);
                    if (beat_q == LAST_BEAT) begin
                        state_d = WR_ACK;
                    end
                end
            end
            WR_ACK: begin
                if (rsp_hs) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they align with it;
    // a stalled read beat keeps beat_d, so the same word is re-presented.
    always_comb begin
        req_ready_d   = (state_d == IDLE);
        wdata_ready_d = (state_d == WR_DATA);
        rsp_valid_d   = (state_d == RD_BURST) || (state_d == WR_ACK);
        rsp_last_d    = (state_d == WR_ACK) ||
                        ((state_d == RD_BURST) && (beat_d == LAST_BEAT));
        busy_d        = (state_d != IDLE);
        rsp_data_d    = '0;
        if (state_d == RD_BURST) begin
            rsp_data_d = mem[rd_idx];
        end
`ifdef RENAS_MEM_ECC_ERR_EN
        rsp_err_d = rsp_valid_d && oor_d;
        if ((state_d == RD_BURST) && oor_d) begin
            rsp_data_d = DATA_W'(32'hDEADBEEF);
        end
`endif
    end

    // Control and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            beat_q        <= '0;
            idx_q         <= '0;
            req_ready_q   <= 1'b0;
            wdata_ready_q <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= '0;
            rsp_last_q    <= 1'b0;
            busy_q        <= 1'b0;
`ifdef RENAS_MEM_ECC_ERR_EN
            oor_q         <= 1'b0;
            rsp_err_q     <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            beat_q        <= beat_d;
            idx_q         <= idx_d;
            req_ready_q   <= req_ready_d;
            wdata_ready_q <= wdata_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_data_q    <= rsp_data_d;
            rsp_last_q    <= rsp_last_d;
            busy_q        <= busy_d;
`ifdef RENAS_MEM_ECC_ERR_EN
            oor_q         <= oor_d;
            rsp_err_q     <= rsp_err_d;
`endif
        end
    end

    // Storage array: not reset, so contents survive a reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_idx] <= wdata;
        end
    end

    assign req_ready   = req_ready_q;
    assign wdata_ready = wdata_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_last    = rsp_last_q;
    assign busy        = busy_q;
`ifdef RENAS_MEM_ECC_ERR_EN
    assign rsp_err     = rsp_err_q;
`endif

endmodule

// File: tb/tb_renas_mem_responder.sv
// Directed testbench for renas_mem_responder (default parameters).
module tb_renas_mem_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr;
    logic        wdata_valid, wdata_ready;
    logic [31:0] wdata;
    logic        rsp_valid, rsp_last, rsp_ready;
    logic [31:0] rsp_data;
    logic        busy;
`ifdef RENAS_MEM_ECC_ERR_EN
    logic        rsp_err;
`endif

    int total = 0;
    int bad   = 0;

    renas_mem_responder dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .wdata_valid(wdata_valid),
        .wdata      (wdata),
        .wdata_ready(wdata_ready),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .rsp_last   (rsp_last),
        .rsp_ready  (rsp_ready),
`ifdef RENAS_MEM_ECC_ERR_EN
        .rsp_err    (rsp_err),
`endif
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present a request and hold it until the accepting edge has passed.
    task automatic send_req(input logic wr, input logic [31:0] addr, input string tag);
        bit ok;
        ok        = 1'b0;
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        for (int i = 0; i < 20; i++) begin
            ok = req_ready;
            step();
            if (ok) break;
        end
        req_valid = 1'b0;
        chk({tag, "_accept"}, 32'(ok), 32'd1);
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] d0, d1, d2, d3,
                            input string tag);
        logic [31:0] d [4];
        bit ok;
        d = '{d0, d1, d2, d3};
        send_req(1'b1, addr, tag);
        for (int b = 0; b < 4; b++) begin
            wdata_valid = 1'b1;
            wdata       = d[b];
            ok          = 1'b0;
            for (int i = 0; i < 20; i++) begin
                ok = wdata_ready;
                step();
                if (ok) break;
            end
            chk({tag, "_wbeat"}, 32'(ok), 32'd1);
        end
        wdata_valid = 1'b0;
        wdata       = 32'hBAD0_BAD0;
        chk({tag, "_ack_valid"}, 32'(rsp_valid), 32'd1);
        chk({tag, "_ack_last"}, 32'(rsp_last), 32'd1);
        chk({tag, "_ack_data"}, rsp_data, 32'd0);
        chk({tag, "_ack_wready"}, 32'(wdata_ready), 32'd0);
        rsp_ready = 1'b1;
        step();
        chk({tag, "_done_ready"}, 32'(req_ready), 32'd1);
        chk({tag, "_done_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_done_busy"}, 32'(busy), 32'd0);
    endtask

    // Read a burst; beat stall_beat is held off for two cycles (-1 = no stall).
    task automatic do_read(input logic [31:0] addr, input logic [31:0] e0, e1, e2, e3,
                           input int stall_beat, input logic exp_err, input string tag);
        logic [31:0] e [4];
        int lat;
        e = '{e0, e1, e2, e3};
        rsp_ready = 1'b1;
        send_req(1'b0, addr, tag);
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            step();
            lat++;
        end
        chk({tag, "_latency"}, 32'(lat), 32'd3);
        for (int b = 0; b < 4; b++) begin
            if (b == stall_beat) begin
                rsp_ready = 1'b0;
                for (int s = 0; s < 2; s++) begin
                    chk({tag, "_stall_valid"}, 32'(rsp_valid), 32'd1);
                    chk({tag, "_stall_data"}, rsp_data, e[b]);
                    step();
                end
                rsp_ready = 1'b1;
            end
            chk({tag, "_valid"}, 32'(rsp_valid), 32'd1);
            chk({tag, "_data"}, rsp_data, e[b]);
            chk({tag, "_last"}, 32'(rsp_last), 32'(b == 3));
`ifdef RENAS_MEM_ECC_ERR_EN
            chk({tag, "_err"}, 32'(rsp_err), 32'(exp_err));
`else
            if (exp_err) chk({tag, "_err_unexpected"}, 32'd0, 32'(exp_err));
`endif
            step();
        end
        chk({tag, "_end_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_end_ready"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        rst_n       = 1'b0;
        req_valid   = 1'b0;
        req_write   = 1'b0;
        req_addr    = '0;
        wdata_valid = 1'b0;
        wdata       = '0;
        rsp_ready   = 1'b1;

        // Reset state.
        repeat (3) step();
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_wdata_ready", 32'(wdata_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_last", 32'(rsp_last), 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        step();
        chk("idle_req_ready", 32'(req_ready), 32'd1);
        chk("idle_busy", 32'(busy), 32'd0);

        // Stray write data while idle is ignored.
        wdata_valid = 1'b1;
        wdata       = 32'hFFFF_FFFF;
        step();
        chk("idle_wdata_ready", 32'(wdata_ready), 32'd0);
        chk("idle_stray_busy", 32'(busy), 32'd0);
        wdata_valid = 1'b0;

        // Writeback to word 0x40..0x43.
        do_write(32'h100, 32'h11, 32'h22, 32'h33, 32'h44, "wr100");

        // Critical word 0x42 first, wrapping in the 4-word block.
        do_read(32'h108, 32'h33, 32'h44, 32'h11, 32'h22, -1, 1'b0, "rd108");

        // Beat 1 held under backpressure.
        do_read(32'h108, 32'h33, 32'h44, 32'h11, 32'h22, 1, 1'b0, "rd108_bp");

        // Reset after beat 0 of a read abandons the burst.
        rsp_ready = 1'b1;
        send_req(1'b0, 32'h100, "rdrst");
        for (int i = 0; i < 20 && !rsp_valid; i++) step();
        chk("rdrst_beat0", rsp_data, 32'h11);
        step();
        chk("rdrst_beat1_valid", 32'(rsp_valid), 32'd1);
        rst_n = 1'b0;
        step();
        chk("rdrst_valid_cleared", 32'(rsp_valid), 32'd0);
        chk("rdrst_busy_cleared", 32'(busy), 32'd0);
        rst_n = 1'b1;
        step();
        chk("rdrst_idle_ready", 32'(req_ready), 32'd1);
        do_read(32'h104, 32'h22, 32'h33, 32'h44, 32'h11, -1, 1'b0, "rd104");

        // Words 0..3, then an address with bits above the storage range.
        do_write(32'h0, 32'hA0, 32'hA1, 32'hA2, 32'hA3, "wr000");
`ifdef RENAS_MEM_ECC_ERR_EN
        do_read(32'h0001_0000, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF,
                -1, 1'b1, "rd_oor");
`else
        do_read(32'h0001_0000, 32'hA0, 32'hA1, 32'hA2, 32'hA3, -1, 1'b0, "rd_wrap");
`endif
        // Earlier data must be untouched by the second write.
        do_read(32'h10C, 32'h44, 32'h11, 32'h22, 32'h33, -1, 1'b0, "rd10c");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
